// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 x 32 storage with a write-back source mux,
// sub-word load extraction and a same-cycle write-through bypass on both read ports.
module wb_regfile (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  RegDst,
    input  logic        RegWr,
    input  logic [1:0]  Digit,
    input  logic        immres,
    input  logic [1:0]  cmp,
    input  logic [31:0] AluOutput,
    input  logic [31:0] PC,
    input  logic [31:0] extend,
    input  logic [31:0] MemData,
    input  logic [4:0]  WrAddr,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] WrData
);

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MEM = 2'b01,
        SRC_PC4 = 2'b10,
        SRC_CMP = 2'b11
    } wbSrc_t;

    typedef enum logic [1:0] {
        LD_WORD  = 2'b00,
        LD_HALF  = 2'b01,
        LD_BYTE  = 2'b10,
        LD_UBYTE = 2'b11
    } ldWidth_t;

    logic [31:0] regs [32];
    logic [15:0] halfLane;
    logic [7:0]  byteLane;
    logic [31:0] loadValue;
    logic        writeHit;

    // Only the byte offset of the address and the less-than flag matter here.
    logic unusedBits;
    assign unusedBits = ^{cmp[1], AluOutput[31:2]};

    // NOTE: every output of a combinational block gets a default before the case,
    // otherwise an unlisted path holds its old value and a latch is inferred.
    always_comb begin
        halfLane  = AluOutput[1] ? MemData[31:16] : MemData[15:0];
        byteLane  = MemData[7:0];
        loadValue = MemData;
        case (AluOutput[1:0])
            2'd1:    byteLane = MemData[15:8];
            2'd2:    byteLane = MemData[23:16];
            2'd3:    byteLane = MemData[31:24];
            default: byteLane = MemData[7:0];
        endcase
        case (ldWidth_t'(Digit))
            LD_HALF:  loadValue = {{16{halfLane[15]}}, halfLane};
            LD_BYTE:  loadValue = {{24{byteLane[7]}}, byteLane};
            LD_UBYTE: loadValue = {24'd0, byteLane};
            default:  loadValue = MemData;
        endcase
    end

    always_comb begin
        WrData = AluOutput;
        if (immres) begin
            WrData = extend;
        end else begin
            case (wbSrc_t'(RegDst))
                SRC_MEM: WrData = loadValue;
                SRC_PC4: WrData = PC + 32'd4;
                SRC_CMP: WrData = {31'd0, cmp[0]};
                default: WrData = AluOutput;
            endcase
        end
    end

    assign writeHit = RegWr && (WrAddr != 5'd0);

    // NOTE: the array is built from flops, not a RAM macro, so it can be cleared
    // asynchronously; reset drops every register to 0 the moment Reset rises.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (writeHit) begin
            regs[WrAddr] <= WrData;
        end
    end

    // Bypass takes priority over storage so it stays visible even during reset.
    assign ReadData1 = (rs == 5'd0) ? 32'd0 :
                       (writeHit && rs == WrAddr) ? WrData : regs[rs];
    assign ReadData2 = (rt == 5'd0) ? 32'd0 :
                       (writeHit && rt == WrAddr) ? WrData : regs[rt];

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised scoreboard bench for wb_regfile: the driver pushes expected outputs
// from a behavioural model, a monitor pops and compares them on the falling edge.
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [1:0]  RegDst;
    logic        RegWr;
    logic [1:0]  Digit;
    logic        immres;
    logic [1:0]  cmp;
    logic [31:0] AluOutput;
    logic [31:0] PC;
    logic [31:0] extend;
    logic [31:0] MemData;
    logic [4:0]  WrAddr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WrData;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] wr;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } expect_t;

    expect_t     expQ[$];
    logic [31:0] model [32];

    wb_regfile dut (
        .CLK(CLK), .Reset(Reset), .RegDst(RegDst), .RegWr(RegWr), .Digit(Digit),
        .immres(immres), .cmp(cmp), .AluOutput(AluOutput), .PC(PC), .extend(extend),
        .MemData(MemData), .WrAddr(WrAddr), .rs(rs), .rt(rt),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WrData(WrData)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, actual, required);
        end
    endtask

    // Reference write-back value from the source rules, using shifts and masks.
    function automatic logic [31:0] refWrData();
        logic [31:0] lane;
        if (immres) return extend;
        case (RegDst)
            2'b00: return AluOutput;
            2'b10: return PC + 32'd4;
            2'b11: return cmp[0] ? 32'd1 : 32'd0;
            default: begin
                if (Digit == 2'b00) return MemData;
                if (Digit == 2'b01) begin
                    lane = (MemData >> (AluOutput[1] ? 16 : 0)) & 32'h0000FFFF;
                    return lane[15] ? (lane | 32'hFFFF0000) : lane;
                end
                lane = (MemData >> (8 * int'(AluOutput[1:0]))) & 32'h000000FF;
                if (Digit == 2'b10 && lane[7]) lane = lane | 32'hFFFFFF00;
                return lane;
            end
        endcase
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] addr, input logic [31:0] wr);
        if (addr == 5'd0) return 32'd0;
        if (RegWr && WrAddr != 5'd0 && addr == WrAddr) return wr;
        if (Reset) return 32'd0;
        return model[addr];
    endfunction

    task automatic issue(input string tag);
        expect_t e;
        e.tag = tag;
        e.wr  = refWrData();
        e.rd1 = refRead(rs, e.wr);
        e.rd2 = refRead(rt, e.wr);
        expQ.push_back(e);
    endtask

    task automatic clockEdge();
        logic [31:0] wr;
        wr = refWrData();
        @(posedge CLK);
        if (Reset) begin
            foreach (model[i]) model[i] = 32'd0;
        end else if (RegWr && WrAddr != 5'd0) begin
            model[WrAddr] = wr;
        end
        #1;
    endtask

    task automatic setIn(input logic wrEn, input logic [4:0] wa, input logic [1:0] dst,
                         input logic imm, input logic [1:0] dg, input logic [1:0] cm,
                         input logic [31:0] alu, input logic [31:0] pcv, input logic [31:0] ext,
                         input logic [31:0] mem, input logic [4:0] a1, input logic [4:0] a2);
        RegWr = wrEn; WrAddr = wa; RegDst = dst; immres = imm; Digit = dg; cmp = cm;
        AluOutput = alu; PC = pcv; extend = ext; MemData = mem; rs = a1; rt = a2;
    endtask

    task automatic step(input string tag);
        issue(tag);
        clockEdge();
    endtask

    // Monitor: combinational outputs are compared mid-cycle, away from the write edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge CLK);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check({e.tag, "_wr"},  WrData,    e.wr);
                check({e.tag, "_rd1"}, ReadData1, e.rd1);
                check({e.tag, "_rd2"}, ReadData2, e.rd2);
            end
        end
    end

    initial begin
        foreach (model[i]) model[i] = 32'd0;
        Reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK); #1;

        setIn(0, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 5, 31);
        step("reset_read");
        setIn(1, 4, 2'b00, 0, 0, 0, 32'hCAFE0004, 0, 0, 0, 4, 4);
        step("reset_bypass");
        Reset = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1);
        step("reset_lost");

        setIn(1, 5, 2'b00, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step("alu_wr_r5");
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step("alu_rd_r5");

        setIn(1, 3, 2'b01, 0, 2'b01, 0, 32'h2, 0, 0, 32'h80017FFF, 0, 0);
        step("half_off2");
        setIn(1, 3, 2'b01, 0, 2'b01, 0, 32'h0, 0, 0, 32'h80017FFF, 3, 0);
        step("half_off0");
        setIn(1, 3, 2'b01, 0, 2'b01, 0, 32'h3, 0, 0, 32'h80017FFF, 3, 3);
        step("half_off3");
        setIn(1, 6, 2'b01, 0, 2'b11, 0, 32'h0, 0, 0, 32'h12345680, 3, 0);
        step("ubyte_off0");
        setIn(1, 6, 2'b01, 0, 2'b10, 0, 32'h0, 0, 0, 32'h12345680, 6, 0);
        step("sbyte_off0");
        setIn(1, 8, 2'b01, 0, 2'b10, 0, 32'h3, 0, 0, 32'h92345680, 6, 8);
        step("sbyte_off3");
        setIn(1, 8, 2'b01, 0, 2'b00, 0, 32'h1, 0, 0, 32'h92345680, 8, 0);
        step("word_load");

        setIn(1, 7, 2'b00, 1, 0, 0, 32'h55, 0, 32'h1234, 0, 7, 7);
        step("imm_bypass");
        setIn(1, 0, 2'b00, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        step("r0_write");
        setIn(1, 31, 2'b10, 0, 0, 0, 0, 32'h00400000, 0, 0, 0, 7);
        step("pc4_r31");
        setIn(1, 30, 2'b10, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 31, 0);
        step("pc4_wrap");
        setIn(1, 29, 2'b11, 0, 0, 2'b10, 0, 0, 0, 0, 30, 29);
        step("cmp_hi_only");
        setIn(1, 28, 2'b11, 0, 0, 2'b11, 0, 0, 0, 0, 29, 28);
        step("cmp_lt");

        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            setIn(1'($urandom_range(0, 3) != 0), wa, 2'($urandom), ($urandom_range(0, 7) == 0),
                  2'($urandom), 2'($urandom), $urandom,
                  ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom,
                  $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
            step("rand");
        end

        for (int r = 1; r < 32; r++) begin
            setIn(1, 5'(r), 2'b00, 0, 0, 0, $urandom | 32'h1, 0, 0, 0, 5'(r - 1), 0);
            step("fill");
        end
        setIn(1, 9, 2'b00, 0, 0, 0, 32'h0000A5A5, 0, 0, 0, 1, 31);
        #2;
        Reset = 1'b1;
        foreach (model[i]) model[i] = 32'd0;
        step("mid_reset");
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 17);
        Reset = 1'b0;
        step("after_reset");
        setIn(1, 9, 2'b00, 0, 0, 0, 32'h00000077, 0, 0, 0, 9, 12);
        step("first_write");
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
        step("first_read");

        @(negedge CLK);
        @(negedge CLK);
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
